// File: rtl/axi4_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_wr_arbiter
// Purpose  : Round-robin AXI4 write arbiter draining per-channel FWFT FIFOs
//            into rotating per-channel frame buffers.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_wr_arbiter #(
    parameter int          C_CH_NUM    = 2,
    parameter int          C_ID_LEN    = 8,
    parameter int          C_DATA_SIZE = 4,
    parameter int          C_BURST_LEN = 128,
    parameter int          C_BUF_SIZE  = 22,
    parameter int          C_BUF_NUM   = 4,
    parameter logic [31:0] C_BASE_ADDR = 32'h0,
    parameter logic [31:0] C_CH_STRIDE = 32'(2**(C_BUF_SIZE + $clog2(C_BUF_NUM))),
    localparam int         C_DATA_LEN  = 8 * (2**C_DATA_SIZE),
    localparam int         C_IDX_W     = $clog2(C_BUF_NUM)
) (
    input  logic                           axi_clk,
    input  logic                           axi_reset,
    input  logic [C_CH_NUM*9-1:0]          ch_level,
    input  logic [C_CH_NUM-1:0]            ch_eof,
    input  logic [C_CH_NUM*C_DATA_LEN-1:0] ch_rdata,
    output logic [C_CH_NUM-1:0]            ch_ren,
    output logic [C_CH_NUM-1:0]            ch_frame_done,
    output logic [C_CH_NUM*C_IDX_W-1:0]    ch_last_index,
    output logic [C_ID_LEN-1:0]            axi_awid,
    output logic [31:0]                    axi_awaddr,
    output logic [7:0]                     axi_awlen,
    output logic [2:0]                     axi_awsize,
    output logic [1:0]                     axi_awburst,
    output logic                           axi_awvalid,
    input  logic                           axi_awready,
    output logic [C_DATA_LEN-1:0]          axi_wdata,
    output logic [C_DATA_LEN/8-1:0]        axi_wstrb,
    output logic                           axi_wlast,
    output logic                           axi_wvalid,
    input  logic                           axi_wready,
    input  logic [C_ID_LEN-1:0]            axi_bid,
    input  logic [1:0]                     axi_bresp,
    input  logic                           axi_bvalid,
    output logic                           axi_bready,
    output logic                           err_bresp,
    output logic                           err_ovf
);

    localparam int C_SEL_W = (C_CH_NUM > 1) ? $clog2(C_CH_NUM) : 1;
    localparam int C_PTR_W = C_BUF_SIZE + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARB       = 3'd1,
        S_ADDR      = 3'd2,
        S_DATA      = 3'd3,
        S_RESP      = 3'd4,
        S_EOF_CLOSE = 3'd5
    } state_t;

    state_t               r_state;
    logic [C_SEL_W-1:0]   r_sel;
    logic [8:0]           r_len;
    logic [8:0]           r_beat;
    logic [C_BUF_SIZE-1:0] r_ptr        [C_CH_NUM];
    logic [C_IDX_W-1:0]   r_wr_index    [C_CH_NUM];
    logic [C_IDX_W-1:0]   r_last_index  [C_CH_NUM];
    logic [C_CH_NUM-1:0]  r_eof_pending;
    logic [C_CH_NUM-1:0]  r_frame_done;
    logic                 r_awvalid;
    logic                 r_wvalid;
    logic                 r_wlast;
    logic                 r_bready;
    logic                 r_err_bresp;
    logic                 r_err_ovf;
    logic [31:0]          r_awaddr;
    logic [7:0]           r_awlen;

    logic [8:0]           w_level       [C_CH_NUM];
    logic [C_CH_NUM-1:0]  w_eligible;
    logic [C_SEL_W-1:0]   w_arb_sel;
    logic                 w_arb_found;
    logic [8:0]           w_sel_level;
    logic [31:0]          w_arb_addr;
    logic [C_PTR_W-1:0]   w_ptr_sum;
    logic                 w_aw_done;
    logic                 w_w_done;
    logic                 w_unused;

    for (genvar gi = 0; gi < C_CH_NUM; gi++) begin : g_ch
        assign w_level[gi]    = ch_level[gi*9 +: 9];
        assign w_eligible[gi] = (w_level[gi] >= 9'(C_BURST_LEN)) || r_eof_pending[gi];
        assign ch_ren[gi]     = r_wvalid && axi_wready && (r_sel == C_SEL_W'(gi));
        assign ch_last_index[gi*C_IDX_W +: C_IDX_W] = r_last_index[gi];
    end

    function automatic logic [C_SEL_W-1:0] f_rr_idx(input logic [C_SEL_W-1:0] base, input int k);
        int v;
        v = int'(base) + k;
        if (v >= C_CH_NUM) v = v - C_CH_NUM;
        return C_SEL_W'(v);
    endfunction

    // Scan farthest-first so the channel nearest after the last served one wins.
    always_comb begin
        w_arb_sel   = r_sel;
        w_arb_found = 1'b0;
        for (int k = C_CH_NUM; k >= 1; k--) begin
            if (w_eligible[f_rr_idx(r_sel, k)]) begin
                w_arb_sel   = f_rr_idx(r_sel, k);
                w_arb_found = 1'b1;
            end
        end
    end

    assign w_sel_level = w_level[w_arb_sel];
    assign w_arb_addr  = C_BASE_ADDR + 32'(w_arb_sel) * C_CH_STRIDE
                       + 32'({r_wr_index[w_arb_sel], r_ptr[w_arb_sel]});
    assign w_ptr_sum   = {1'b0, r_ptr[r_sel]} + (C_PTR_W'(r_len) << C_DATA_SIZE);

    // Each handshake is "done" once its valid is low or drops at this edge.
    assign w_aw_done = !r_awvalid || axi_awready;
    assign w_w_done  = !r_wvalid || (axi_wready && r_wlast);

    assign axi_awid      = '0;
    assign axi_awaddr    = r_awaddr;
    assign axi_awlen     = r_awlen;
    assign axi_awsize    = 3'(C_DATA_SIZE);
    assign axi_awburst   = 2'b01;
    assign axi_awvalid   = r_awvalid;
    assign axi_wdata     = ch_rdata[int'(r_sel)*C_DATA_LEN +: C_DATA_LEN];
    assign axi_wstrb     = '1;
    assign axi_wlast     = r_wlast;
    assign axi_wvalid    = r_wvalid;
    assign axi_bready    = r_bready;
    assign ch_frame_done = r_frame_done;
    assign err_bresp     = r_err_bresp;
    assign err_ovf       = r_err_ovf;
    assign w_unused      = ^axi_bid;

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            r_state       <= S_IDLE;
            r_sel         <= C_SEL_W'(C_CH_NUM - 1);
            r_len         <= '0;
            r_beat        <= '0;
            r_eof_pending <= '0;
            r_frame_done  <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_wlast       <= 1'b0;
            r_bready      <= 1'b0;
            r_err_bresp   <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_awaddr      <= '0;
            r_awlen       <= '0;
            for (int i = 0; i < C_CH_NUM; i++) begin
                r_ptr[i]        <= '0;
                r_wr_index[i]   <= '0;
                r_last_index[i] <= '0;
            end
        end else begin
            r_frame_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|w_eligible) r_state <= S_ARB;
                end
                S_ARB: begin
                    r_sel  <= w_arb_sel;
                    r_beat <= '0;
                    if (!w_arb_found) begin
                        r_state <= S_IDLE;
                    end else if (w_sel_level >= 9'(C_BURST_LEN)) begin
                        r_len     <= 9'(C_BURST_LEN);
                        r_awlen   <= 8'(C_BURST_LEN - 1);
                        r_awaddr  <= w_arb_addr;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= 1'b0;
                        r_state   <= S_ADDR;
                    end else if (w_sel_level != 9'd0) begin
                        // Only reachable with eof pending: flush the frame tail.
                        r_len     <= w_sel_level;
                        r_awlen   <= 8'(w_sel_level - 9'd1);
                        r_awaddr  <= w_arb_addr;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= (w_sel_level == 9'd1);
                        r_state   <= S_ADDR;
                    end else begin
                        r_state <= S_EOF_CLOSE;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (r_awvalid && axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && axi_wready) begin
                        r_beat  <= r_beat + 9'd1;
                        r_wlast <= (({1'b0, r_beat} + 10'd2) == {1'b0, r_len});
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                        end
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_RESP: begin
                    if (axi_bvalid) begin
                        r_ptr[r_sel] <= w_ptr_sum[C_BUF_SIZE-1:0];
                        if (w_ptr_sum[C_BUF_SIZE]) r_err_ovf <= 1'b1;
                        if (axi_bresp != 2'b00) r_err_bresp <= 1'b1;
                        r_bready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_EOF_CLOSE: begin
                    r_last_index[r_sel]  <= r_wr_index[r_sel];
                    r_wr_index[r_sel]    <= r_wr_index[r_sel] + C_IDX_W'(1);
                    r_ptr[r_sel]         <= '0;
                    r_eof_pending[r_sel] <= 1'b0;
                    r_frame_done[r_sel]  <= 1'b1;
                    r_state              <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // A fresh end-of-frame on the same edge as a close re-arms the channel.
            for (int i = 0; i < C_CH_NUM; i++) begin
                if (ch_eof[i]) r_eof_pending[i] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
